// File: rtl/ps2_host_tx_if.sv
// CPU IO bus side of the PS/2 host transmitter.
// The bus drives start/data; the transmitter returns handshake and status.
interface ps2_host_tx_if;
    logic       start;
    logic [7:0] data;
    logic       rdy;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err;

    modport master (output start, data, input rdy, busy, done, ack_ok, err);
    modport slave  (input start, data, output rdy, busy, done, ack_ok, err);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send, then shifts
// one command byte plus parity/stop on device clock falls and checks the device ack.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 3000,
    parameter int unsigned TIMEOUT_CYCLES = 375000,
    parameter int unsigned FILT_CYCLES    = 8
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2c_in,
    input  logic          ps2d_in,
    output logic          ps2c_oe,
    output logic          ps2d_oe
);
    localparam int unsigned INH_W  = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned FILT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_BITS, S_ACK, S_WAITIDLE, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [9:0]         sh_q, sh_d;
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic [INH_W-1:0]   inh_q, inh_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               c_oe_q, c_oe_d, d_oe_q, d_oe_d;
    logic               rdy_q, rdy_d, done_q, done_d;
    logic               ack_ok_q, ack_ok_d, err_q, err_d;

    logic               c_meta_q, c_sync_q, d_meta_q, d_sync_q;
    logic               c_filt_q;
    logic [FILT_W-1:0]  filt_cnt_q;
    logic               fall_c;
    logic               device_phase_c;

    // Synchronisers and clock deglitch: a level change must persist FILT_CYCLES to be accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_meta_q   <= 1'b1;
            c_sync_q   <= 1'b1;
            d_meta_q   <= 1'b1;
            d_sync_q   <= 1'b1;
            c_filt_q   <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            c_meta_q <= ps2c_in;
            c_sync_q <= c_meta_q;
            d_meta_q <= ps2d_in;
            d_sync_q <= d_meta_q;
            if (c_sync_q != c_filt_q) begin
                if (filt_cnt_q == FILT_W'(FILT_CYCLES - 1)) begin
                    c_filt_q   <= c_sync_q;
                    filt_cnt_q <= '0;
                end else begin
                    filt_cnt_q <= filt_cnt_q + FILT_W'(1);
                end
            end else begin
                filt_cnt_q <= '0;
            end
        end
    end

    assign fall_c = c_filt_q & ~c_sync_q & (filt_cnt_q == FILT_W'(FILT_CYCLES - 1));
    assign device_phase_c = (state_q == S_REQ) || (state_q == S_BITS) ||
                            (state_q == S_ACK) || (state_q == S_WAITIDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sh_q     <= '0;
            bitcnt_q <= '0;
            inh_q    <= '0;
            tmo_q    <= '0;
            c_oe_q   <= 1'b0;
            d_oe_q   <= 1'b0;
            rdy_q    <= 1'b1;
            done_q   <= 1'b0;
            ack_ok_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            bitcnt_q <= bitcnt_d;
            inh_q    <= inh_d;
            tmo_q    <= tmo_d;
            c_oe_q   <= c_oe_d;
            d_oe_q   <= d_oe_d;
            rdy_q    <= rdy_d;
            done_q   <= done_d;
            ack_ok_q <= ack_ok_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bitcnt_d = bitcnt_q;
        inh_d    = inh_q;
        tmo_d    = tmo_q;
        c_oe_d   = c_oe_q;
        d_oe_d   = d_oe_q;
        done_d   = 1'b0;
        ack_ok_d = ack_ok_q;
        err_d    = err_q;

        if (device_phase_c) begin
            tmo_d = fall_c ? '0 : tmo_q + TMO_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sh_d     = {1'b1, ~^bus.data, bus.data};
                    ack_ok_d = 1'b0;
                    err_d    = 1'b0;
                    c_oe_d   = 1'b1;
                    inh_d    = '0;
                    bitcnt_d = '0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                inh_d = inh_q + INH_W'(1);
                if (inh_q == INH_W'(INHIBIT_CYCLES - 2)) begin
                    d_oe_d = 1'b1;
                end
                if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    c_oe_d  = 1'b0;
                    tmo_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ, S_BITS: begin
                // Shift out on falls only, so data moves while the device holds clock low.
                if (fall_c) begin
                    d_oe_d = ~sh_q[0];
                    sh_d   = {1'b1, sh_q[9:1]};
                    if (state_q == S_REQ) begin
                        bitcnt_d = 4'd1;
                        state_d  = S_BITS;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end
            end
            S_ACK: begin
                if (fall_c) begin
                    ack_ok_d = ~d_sync_q;
                    err_d    = d_sync_q;
                    state_d  = S_WAITIDLE;
                end
            end
            S_WAITIDLE: begin
                if (c_sync_q && d_sync_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort when the device stops clocking; the fall check keeps a late edge from racing it.
        if (device_phase_c && !fall_c && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
            c_oe_d   = 1'b0;
            d_oe_d   = 1'b0;
            err_d    = 1'b1;
            ack_ok_d = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
        end

        rdy_d = (state_d == S_IDLE);
    end

    assign ps2c_oe    = c_oe_q;
    assign ps2d_oe    = d_oe_q;
    assign bus.rdy    = rdy_q;
    assign bus.busy   = ~rdy_q;
    assign bus.done   = done_q;
    assign bus.ack_ok = ack_ok_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a timed PS/2 device model clocks frames out of the DUT and
// compares the sampled bits against the frame built from the byte by a reference function.
module tb_ps2_host_tx;
    localparam int unsigned INH  = 200;
    localparam int unsigned TMO  = 1000;
    localparam int unsigned FILT = 8;
    localparam int unsigned HALF = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_c = 1'b1;
    logic dev_d = 1'b1;
    logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_total = 0;

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILT_CYCLES(FILT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe)
    );

    // Open-drain wired-AND of host overrides and device drive.
    assign ps2c_in = ~ps2c_oe & dev_c;
    assign ps2d_in = ~ps2d_oe & dev_d;

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.done) done_total <= done_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected wire frame: data LSB first, odd parity, stop 1.
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += (d >> i) & 1;
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic pulse_start(input logic [7:0] d);
        @(negedge clk);
        bus.data  = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("rdy_after_start", 32'(bus.rdy), 32'd0);
    endtask

    // Device side: measures the inhibit, then produces up to stop_after clock falls.
    task automatic dev_frame(input int stop_after, input bit ack_low, input bit glitch,
                             input bit busy_start, output logic [9:0] got,
                             output logic start_low, output int inh_len);
        int f;
        got = '0;
        inh_len = 0;
        while (ps2c_oe && inh_len < int'(INH) * 2 + 10) begin
            @(negedge clk);
            inh_len++;
            if (busy_start && inh_len == 5) begin
                bus.data  = 8'h55;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        start_low = ~ps2d_in;
        if (glitch && stop_after > 0) begin
            repeat (20) @(negedge clk);
            dev_c = 1'b0;
            repeat (3) @(negedge clk);
            dev_c = 1'b1;
            repeat (20) @(negedge clk);
        end
        f = 1;
        while (f <= 11 && f <= stop_after) begin
            repeat (HALF) @(negedge clk);
            dev_c = 1'b0;
            repeat (HALF) @(negedge clk);
            if (f <= 10) got[f-1] = ps2d_in;
            dev_c = 1'b1;
            if (f == 10 && ack_low) dev_d = 1'b0;
            if (f == 11) begin
                repeat (5) @(negedge clk);
                dev_d = 1'b1;
            end
            f++;
        end
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!bus.rdy && n < int'(TMO) * 2) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < int'(TMO) * 2), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack_low, input bit glitch,
                             input bit busy_start);
        logic [9:0] got;
        logic       start_low;
        int         inh_len;
        int         done0 = done_total;
        pulse_start(d);
        dev_frame(11, ack_low, glitch, busy_start, got, start_low, inh_len);
        wait_rdy("frame_rdy_wait");
        check($sformatf("bits_%02h", d), 32'(got), 32'(ref_frame(d)));
        check("inhibit_len", 32'(inh_len >= int'(INH) && inh_len < int'(INH) + 4), 32'd1);
        check("start_bit_low", 32'(start_low), 32'd1);
        check("ack_ok", 32'(bus.ack_ok), 32'(ack_low));
        check("err", 32'(bus.err), 32'(!ack_low));
        check("done_pulses", 32'(done_total - done0), 32'd1);
        check("lines_released", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    endtask

    initial begin
        logic [9:0] got;
        logic       start_low;
        int         inh_len;
        int         k;
        int         done0;

        bus.start = 1'b0;
        bus.data  = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", 32'(bus.rdy), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ack_err", 32'({bus.ack_ok, bus.err}), 32'd0);
        check("rst_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);

        run_frame(8'hED, 1'b1, 1'b0, 1'b0);
        run_frame(8'hF4, 1'b1, 1'b0, 1'b0);
        run_frame(8'h00, 1'b1, 1'b0, 1'b0);
        run_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) run_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
        run_frame(8'hF5, 1'b1, 1'b1, 1'b0);
        run_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);

        // Device never clocks after the request.
        done0 = done_total;
        pulse_start(8'hF4);
        dev_frame(0, 1'b1, 1'b0, 1'b0, got, start_low, inh_len);
        k = 0;
        while (ps2d_oe && k < int'(TMO) + 50) begin
            @(negedge clk);
            k++;
        end
        check("tmo_req_cycles", 32'(k), 32'(TMO));
        wait_rdy("tmo_req_rdy_wait");
        check("tmo_req_err", 32'(bus.err), 32'd1);
        check("tmo_req_done", 32'(done_total - done0), 32'd1);

        // Device stops after fall 5.
        done0 = done_total;
        pulse_start(8'hA7);
        dev_frame(5, 1'b1, 1'b0, 1'b0, got, start_low, inh_len);
        k = 0;
        while (!bus.rdy && k < int'(TMO) + 50) begin
            @(negedge clk);
            k++;
        end
        check("tmo_bits_window",
              32'(k >= int'(TMO - HALF) + 5 && k <= int'(TMO - HALF) + 15), 32'd1);
        check("tmo_bits_err", 32'({bus.err, bus.ack_ok}), 32'b10);
        check("tmo_bits_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
        check("tmo_bits_rdy", 32'(bus.rdy), 32'd1);
        check("tmo_bits_done", 32'(done_total - done0), 32'd1);

        // Reset in the middle of the data bits.
        pulse_start(8'h3C);
        dev_frame(3, 1'b1, 1'b0, 1'b0, got, start_low, inh_len);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
        check("midrst_rdy", 32'({bus.rdy, bus.busy}), 32'b10);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        run_frame(8'h81, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "bench time limit");
    end
endmodule
